// File: rtl/caxi4interconnect_wr_src_fifo.sv
// ---------------------------------------------------------------------------
// caxi4interconnect_wr_src_fifo
//
// Per-slave write-ordering FIFO. It sits upstream of the write data mux and
// remembers which master won each AW grant toward this slave. The head entry
// steers the W channel to that master. The entry is retired when the data mux
// reports the last beat of the burst.
//
// Ports
//   sysClk         system clock, rising edge
//   sysReset       asynchronous, active-low reset
//   awPush         AW handshake to this slave completed this cycle
//   awMaster       master number granted for that AW
//   fifoFull       no free entry; the AW arbiter must not grant this slave
//   wrMasterValid  head entry valid (FIFO non-empty)
//   srcMaster      master number in the head entry (0 when empty)
//   dataFifoRd     pop request: last W beat transferred
//   fifoCount      current occupancy, 0..DEPTH
//   overflowErr    sticky: push seen while full with no pop
//   underflowErr   sticky: pop seen while empty
// ---------------------------------------------------------------------------
module caxi4interconnect_wr_src_fifo #(
    parameter int NUM_MASTERS_WIDTH = 2,
    parameter int DEPTH_WIDTH       = 2
) (
    input  logic                         sysClk,
    input  logic                         sysReset,
    input  logic                         awPush,
    input  logic [NUM_MASTERS_WIDTH-1:0] awMaster,
    output logic                         fifoFull,
    output logic                         wrMasterValid,
    output logic [NUM_MASTERS_WIDTH-1:0] srcMaster,
    input  logic                         dataFifoRd,
    output logic [DEPTH_WIDTH:0]         fifoCount,
    output logic                         overflowErr,
    output logic                         underflowErr
);

    localparam int                DEPTH     = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH + 1)'(DEPTH);

    logic [NUM_MASTERS_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_WIDTH-1:0]       wr_ptr;
    logic [DEPTH_WIDTH-1:0]       rd_ptr;
    logic [DEPTH_WIDTH:0]         count;

    logic pop_ok;
    logic push_ok;

    // Status outputs come from registered state only. There is no
    // combinational path from awPush/dataFifoRd to any output.
    assign wrMasterValid = (count != '0);
    assign fifoFull      = (count == DEPTH_CNT);
    assign fifoCount     = count;
    assign srcMaster     = wrMasterValid ? mem[rd_ptr] : '0;

    // A pop on an empty FIFO is never accepted. A push into a full FIFO is
    // accepted only when a pop frees the head entry in the same cycle.
    assign pop_ok  = dataFifoRd & wrMasterValid;
    assign push_ok = awPush & (~fifoFull | pop_ok);

    // NOTE: the storage array is deliberately left out of the reset. The count
    // gates every read, so stale contents are never observed, and a reset-free
    // array can map onto plain flops or distributed RAM.
    always_ff @(posedge sysClk) begin
        if (push_ok) begin
            mem[wr_ptr] <= awMaster;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Each register
    // then samples the pre-edge value of every other register, whatever order
    // the statements appear in.
    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflowErr  <= 1'b0;
            underflowErr <= 1'b0;
        end else begin
            // The pointers wrap naturally because they are DEPTH_WIDTH bits wide.
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end

            if (awPush && !push_ok) begin
                overflowErr <= 1'b1;
            end
            if (dataFifoRd && !wrMasterValid) begin
                underflowErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_caxi4interconnect_wr_src_fifo.sv
// ---------------------------------------------------------------------------
// tb_caxi4interconnect_wr_src_fifo
//
// Scoreboard bench for the write-ordering FIFO. The stimulus process drives
// awPush/awMaster/dataFifoRd and keeps the reference model: a queue of master
// numbers plus sticky error bits. Whenever the model accepts a pop, the
// expected head master is pushed into exp_q. A separate monitor watches for
// the DUT retiring an entry (dataFifoRd & wrMasterValid) and compares
// srcMaster against the front of exp_q.
// ---------------------------------------------------------------------------
module tb_caxi4interconnect_wr_src_fifo;

    localparam int NMW   = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 1 << DW;

    logic           sysClk;
    logic           sysReset;
    logic           awPush;
    logic [NMW-1:0] awMaster;
    logic           fifoFull;
    logic           wrMasterValid;
    logic [NMW-1:0] srcMaster;
    logic           dataFifoRd;
    logic [DW:0]    fifoCount;
    logic           overflowErr;
    logic           underflowErr;

    caxi4interconnect_wr_src_fifo #(
        .NUM_MASTERS_WIDTH(NMW),
        .DEPTH_WIDTH      (DW)
    ) dut (
        .sysClk       (sysClk),
        .sysReset     (sysReset),
        .awPush       (awPush),
        .awMaster     (awMaster),
        .fifoFull     (fifoFull),
        .wrMasterValid(wrMasterValid),
        .srcMaster    (srcMaster),
        .dataFifoRd   (dataFifoRd),
        .fifoCount    (fifoCount),
        .overflowErr  (overflowErr),
        .underflowErr (underflowErr)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int model_q[$];
    int exp_q[$];
    bit ovf_m = 1'b0;
    bit unf_m = 1'b0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output with the model after a clock edge.
    task automatic check_state(input string tag);
        check({tag, ".count"}, fifoCount, model_q.size());
        check({tag, ".full"},  fifoFull,  model_q.size() == DEPTH);
        check({tag, ".valid"}, wrMasterValid, model_q.size() != 0);
        check({tag, ".src"},   srcMaster, (model_q.size() != 0) ? model_q[0] : 0);
        check({tag, ".ovf"},   overflowErr,  ovf_m);
        check({tag, ".unf"},   underflowErr, unf_m);
    endtask

    // Drive one cycle of stimulus. The task is entered at posedge+1 and returns
    // at the next posedge+1, after the outputs have been checked.
    task automatic step(input bit push, input int master, input bit pop,
                        input string tag);
        bit pop_acc;
        bit push_acc;
        awPush     = push;
        awMaster   = NMW'(master);
        dataFifoRd = pop;

        pop_acc  = pop && (model_q.size() != 0);
        push_acc = push && ((model_q.size() < DEPTH) || pop_acc);
        if (pop && !pop_acc)   unf_m = 1'b1;
        if (push && !push_acc) ovf_m = 1'b1;
        if (pop_acc) begin
            exp_q.push_back(model_q[0]);
            void'(model_q.pop_front());
        end
        if (push_acc) model_q.push_back(master);

        @(posedge sysClk);
        #1;
        awPush     = 1'b0;
        dataFifoRd = 1'b0;
        check_state(tag);
    endtask

    // Monitor: the DUT retires its head entry when dataFifoRd meets
    // wrMasterValid. The entry it presents must be the next expected one.
    always @(negedge sysClk) begin
        if (sysReset && dataFifoRd && wrMasterValid) begin
            if (exp_q.size() == 0) begin
                check("mon.unexpected_pop", 1, 0);
            end else begin
                check("mon.pop_src", srcMaster, exp_q.pop_front());
            end
        end
    end

    // Watchdog: the run is a fixed number of clocks, so this only fires if
    // something stops the clock loop from advancing.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        awPush     = 1'b0;
        awMaster   = '0;
        dataFifoRd = 1'b0;
        sysReset   = 1'b0;
        #2;
        check_state("reset");
        #10 sysReset = 1'b1;
        @(posedge sysClk);
        #1;

        // Single push, then a single pop.
        step(1, 2, 0, "p1.push");
        step(0, 0, 0, "p1.idle");
        step(0, 0, 1, "p1.pop");

        // Fill to full, attempt an overflow, then drain in order.
        step(1, 1, 0, "fill.0");
        step(1, 3, 0, "fill.1");
        step(1, 0, 0, "fill.2");
        step(1, 2, 0, "fill.3");
        step(1, 1, 0, "ovf");
        for (int i = 0; i < 4; i++) step(0, 0, 1, "drain");

        // Fill again, push 3 together with a pop, then drain across the wrap.
        step(1, 1, 0, "wrap.f0");
        step(1, 3, 0, "wrap.f1");
        step(1, 0, 0, "wrap.f2");
        step(1, 2, 0, "wrap.f3");
        step(1, 3, 1, "wrap.pp");
        for (int i = 0; i < 4; i++) step(0, 0, 1, "wrap.drain");

        // Underflow on its own, then a push and a pop together while empty.
        step(0, 0, 1, "unf");
        step(1, 1, 1, "empty.pp");
        step(0, 0, 1, "empty.drain");

        // Streaming with the occupancy held at 2.
        step(1, 2, 0, "stream.f0");
        step(1, 0, 0, "stream.f1");
        for (int i = 0; i < 20; i++) step(1, int'($urandom_range(0, 3)), 1, "stream");
        step(0, 0, 1, "stream.d0");
        step(0, 0, 1, "stream.d1");

        // Reset in the middle of a cycle with three entries queued and
        // overflowErr set.
        sysReset = 1'b0;
        #2 sysReset = 1'b1;
        @(posedge sysClk);
        #1;
        model_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        step(1, 3, 0, "mr.f0");
        step(1, 1, 0, "mr.f1");
        step(1, 2, 0, "mr.f2");
        step(1, 0, 0, "mr.f3");
        step(1, 1, 0, "mr.ovf");
        step(0, 0, 1, "mr.pop");
        #3;
        sysReset = 1'b0;
        model_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        #1;
        check_state("mr.async");
        @(negedge sysClk);
        sysReset = 1'b1;
        @(posedge sysClk);
        #1;
        step(1, 2, 0, "mr.push");
        step(0, 0, 1, "mr.pop2");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), "rand");
        end
        while (model_q.size() != 0) step(0, 0, 1, "final.drain");
        step(0, 0, 0, "final.idle");
        check("scoreboard.empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/caxi4interconnect_wr_src_fifo.md
Name: caxi4interconnect_wr_src_fifo

Overview:
- Per-slave write-ordering FIFO that sits directly upstream of the write data mux.
- Each accepted AW handshake toward this slave pushes the granted master number.
- The head entry is presented as srcMaster/wrMasterValid, which steers W-channel data from that master.
- The entry is popped on dataFifoRd, the last-beat completion from the data mux.
- fifoFull back-pressures the AW arbiter so outstanding writes never exceed depth.

Parameters:
- NUM_MASTERS_WIDTH, 2, bits encoding the master number.
- DEPTH_WIDTH, 2, log2 of FIFO depth; DEPTH = 2**DEPTH_WIDTH (default 4 outstanding writes).

Ports:
- sysClk  input  1  system clock, rising edge.
- sysReset  input  1  reset, asynchronous, active-low.
- awPush  input  1  AW handshake completed to this slave this cycle (AWVALID & AWREADY).
- awMaster  input  NUM_MASTERS_WIDTH  master number granted for that AW.
- fifoFull  output  1  no free entry; the arbiter must not grant this slave.
- wrMasterValid  output  1  head entry valid (FIFO non-empty).
- srcMaster  output  NUM_MASTERS_WIDTH  master number in head entry.
- dataFifoRd  input  1  pop request; W last beat transferred.
- fifoCount  output  DEPTH_WIDTH+1  current occupancy, 0..DEPTH.
- overflowErr  output  1  sticky; push attempted while full with no pop.
- underflowErr  output  1  sticky; pop attempted while empty.

Behaviour:
- Storage: DEPTH x NUM_MASTERS_WIDTH register array. Write pointer wrPtr and read pointer rdPtr are DEPTH_WIDTH bits and wrap modulo DEPTH. Occupancy counter is DEPTH_WIDTH+1 bits.
- Reset (sysReset low, asynchronous): wrPtr=0, rdPtr=0, count=0, overflowErr=0, underflowErr=0. Consequently fifoFull=0, wrMasterValid=0, srcMaster=0. The storage array is not reset.
- Derived outputs (combinational from registers only, with no path from inputs):
  - wrMasterValid = (count != 0).
  - fifoFull = (count == DEPTH).
  - srcMaster = mem[rdPtr] when wrMasterValid, else 0.
  - fifoCount = count.
- Push accepted when awPush & (!fifoFull | popOK):
  - mem[wrPtr] <= awMaster; wrPtr <= wrPtr+1.
- Pop accepted (popOK) when dataFifoRd & wrMasterValid:
  - rdPtr <= rdPtr+1.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Latency:
  - Push in cycle N: wrMasterValid/srcMaster reflect the entry from cycle N+1.
  - No same-cycle bypass from awMaster to srcMaster.
  - Pop in cycle N: next entry (or empty) visible in N+1.
- Empty + simultaneous push & pop:
  - The pop is not accepted and sets underflowErr.
  - The push is accepted; count becomes 1.
- Full + simultaneous push & pop: both accepted, count stays DEPTH, no error.
- Full + push without pop: push dropped, pointers and count unchanged, overflowErr <= 1.
- Empty + pop without push: ignored, underflowErr <= 1.
- Error flags are sticky and clear only on reset.
- Pointer wrap: after DEPTH pushes, wrPtr returns to 0. Ordering is strictly FIFO across the wrap.
- Reset mid-operation: all queued entries are discarded immediately (asynchronous); outputs reach reset values in the same cycle.
- No other state; the block is a single implicit state machine (EMPTY / PARTIAL / FULL) derived from count.

Test Plan:
- Reset, then push awMaster=2 at cycle 1 -> cycle 2: wrMasterValid=1, srcMaster=2, fifoCount=1; pop at cycle 3 -> cycle 4: wrMasterValid=0, srcMaster=0, fifoCount=0.
- Push 1,3,0,2 on consecutive cycles (DEPTH=4) -> fifoFull=1, fifoCount=4. Then push 1 without pop -> overflowErr=1, count stays 4. Four pops return 1,3,0,2 in order.
- Fill to 4, then push 3 with simultaneous pop -> fifoCount=4, no error. Subsequent pops yield 3,0,2,3 (wrap order intact); wrPtr and rdPtr have wrapped.
- Empty FIFO, dataFifoRd=1 alone -> underflowErr=1, count 0. Same cycle push 1 + pop on empty -> count=1, srcMaster=1 next cycle.
- Continuous streaming: push and pop every cycle for 20 cycles with count held at 2 -> srcMaster sequence matches pushed sequence delayed by 2 entries; no error flags.
- With 3 entries queued and overflowErr=1, assert sysReset low mid-cycle -> outputs immediately 0, fifoCount=0, overflowErr=0. Push after release -> normal operation.
